// File: rtl/operand_forward_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// operand_forward_ctrl_pkg
// Shared definitions for the EX-stage operand forwarding controller:
//   - register specifier and mux select widths
//   - ALU operand mux select encoding
//   - shadow pipeline slot record {valid, reg_write, mem_read, dest}
//   - is_producer(): slot will write a non-zero register
// ----------------------------------------------------------------------------
package operand_forward_ctrl_pkg;

   localparam int unsigned NB_REG = 5;
   localparam int unsigned NB_SEL = 2;

   // Operand mux select encoding; 2'b11 is never driven.
   localparam logic [NB_SEL-1:0] SEL_REGFILE = 2'b00;
   localparam logic [NB_SEL-1:0] SEL_EXMEM   = 2'b01;
   localparam logic [NB_SEL-1:0] SEL_MEMWB   = 2'b10;

   typedef struct packed {
      logic              valid;
      logic              reg_write;
      logic              mem_read;
      logic [NB_REG-1:0] dest;
   } slot_t;

   // $0 is hard-wired to zero, so a write to it never produces a value.
   function automatic logic is_producer(slot_t s);
      return s.valid & s.reg_write & (s.dest != '0);
   endfunction

endpackage

// File: rtl/operand_forward_ctrl_fwd_sel_compare.sv
// ----------------------------------------------------------------------------
// operand_forward_ctrl_fwd_sel_compare (fwd_sel_compare)
// Purely combinational select generator for one ALU operand.
// Ports:
//   src_i          source register of the instruction entering EX
//   ex_producer_i  EX slot will write a non-zero register
//   ex_dest_i      EX slot destination
//   mem_producer_i MEM slot will write a non-zero register
//   mem_dest_i     MEM slot destination
//   sel_o          operand mux select (EX match beats MEM match)
// ----------------------------------------------------------------------------
module operand_forward_ctrl_fwd_sel_compare #(
   parameter int NB_REG = 5
) (
   input  logic [NB_REG-1:0] src_i,
   input  logic              ex_producer_i,
   input  logic [NB_REG-1:0] ex_dest_i,
   input  logic              mem_producer_i,
   input  logic [NB_REG-1:0] mem_dest_i,
   output logic [1:0]        sel_o
);
   import operand_forward_ctrl_pkg::*;

   always_comb begin
      sel_o = SEL_REGFILE;
      // The youngest producer holds the most recent value of the register.
      if (ex_producer_i && (ex_dest_i == src_i)) begin
         sel_o = SEL_EXMEM;
      end else if (mem_producer_i && (mem_dest_i == src_i)) begin
         sel_o = SEL_MEMWB;
      end
   end

endmodule

// File: rtl/operand_forward_ctrl.sv
// ----------------------------------------------------------------------------
// operand_forward_ctrl
// Forwarding and load-use stall controller for the ALU A/B operand muxes.
// Keeps a shadow copy {valid, reg_write, mem_read, dest} of the EX, MEM and
// WB instructions and registers the mux selects for the instruction that
// enters EX on each enabled edge.
// Ports:
//   clock_i, reset_i        clock (rising edge), async active-high reset
//   enable_i                pipeline advance; low freezes all state
//   flush_i                 squash the ID instruction
//   id_*                    decoded fields of the ID-stage instruction
//   stall_o                 hold PC and IF/ID (combinational)
//   fwd_a_sel_o/fwd_b_sel_o registered operand mux selects
//   stall_count_o           stall cycle counter (OPERAND_FORWARD_STALL_COUNT_EN)
// Optional feature macro: OPERAND_FORWARD_STALL_COUNT_EN
// ----------------------------------------------------------------------------
module operand_forward_ctrl #(
   parameter int NB_REG = 5,
   parameter int NB_SEL = 2
) (
   input  logic              clock_i,
   input  logic              reset_i,
   input  logic              enable_i,
   input  logic              flush_i,
   input  logic              id_valid_i,
   input  logic [NB_REG-1:0] id_rs_i,
   input  logic [NB_REG-1:0] id_rt_i,
   input  logic              id_use_rs_i,
   input  logic              id_use_rt_i,
   input  logic              id_reg_write_i,
   input  logic [NB_REG-1:0] id_dest_i,
   input  logic              id_mem_read_i,
   output logic              stall_o,
   output logic [NB_SEL-1:0] fwd_a_sel_o,
   output logic [NB_SEL-1:0] fwd_b_sel_o
`ifdef OPERAND_FORWARD_STALL_COUNT_EN
   ,
   output logic [31:0]       stall_count_o
`endif
);
   import operand_forward_ctrl_pkg::*;

   slot_t             ex_q, ex_d;
   slot_t             mem_q, mem_d;
   slot_t             wb_q, wb_d;
   slot_t             id_slot;
   logic [NB_SEL-1:0] sel_a_q, sel_a_d;
   logic [NB_SEL-1:0] sel_b_q, sel_b_d;
   logic [1:0]        cmp_a_sel, cmp_b_sel;
   logic              ex_is_load;
   logic              load_use;
   logic              insert_bubble;

   // WB is tracked only to mirror the real pipeline: the register file
   // writes before it reads, so a WB producer never needs forwarding.
   logic              unused_wb;
   assign unused_wb = ^wb_q;

   assign id_slot = '{valid:     1'b1,
                      reg_write: id_reg_write_i,
                      mem_read:  id_mem_read_i,
                      dest:      id_dest_i};

   // Load-use: the load value is only available after MEM, so a consumer
   // directly behind a load must wait one cycle.
   always_comb begin
      ex_is_load = ex_q.valid & ex_q.mem_read & ex_q.reg_write & (ex_q.dest != '0);
      load_use   = (id_use_rs_i & (id_rs_i == ex_q.dest)) |
                   (id_use_rt_i & (id_rt_i == ex_q.dest));
      stall_o    = enable_i & ~flush_i & id_valid_i & ex_is_load & load_use;
   end

   assign insert_bubble = stall_o | flush_i | ~id_valid_i;

   operand_forward_ctrl_fwd_sel_compare #(
      .NB_REG(NB_REG)
   ) u_cmp_a (
      .src_i          (id_rs_i),
      .ex_producer_i  (is_producer(ex_q)),
      .ex_dest_i      (ex_q.dest),
      .mem_producer_i (is_producer(mem_q)),
      .mem_dest_i     (mem_q.dest),
      .sel_o          (cmp_a_sel)
   );

   operand_forward_ctrl_fwd_sel_compare #(
      .NB_REG(NB_REG)
   ) u_cmp_b (
      .src_i          (id_rt_i),
      .ex_producer_i  (is_producer(ex_q)),
      .ex_dest_i      (ex_q.dest),
      .mem_producer_i (is_producer(mem_q)),
      .mem_dest_i     (mem_q.dest),
      .sel_o          (cmp_b_sel)
   );

   always_comb begin
      ex_d    = ex_q;
      mem_d   = mem_q;
      wb_d    = wb_q;
      sel_a_d = sel_a_q;
      sel_b_d = sel_b_q;
      if (enable_i) begin
         wb_d  = mem_q;
         mem_d = ex_q;
         ex_d  = insert_bubble ? '0 : id_slot;
         // A bubble carries no operands, so its selects fall back to the RF.
         sel_a_d = (insert_bubble | ~id_use_rs_i) ? SEL_REGFILE : cmp_a_sel;
         sel_b_d = (insert_bubble | ~id_use_rt_i) ? SEL_REGFILE : cmp_b_sel;
      end
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         ex_q    <= '0;
         mem_q   <= '0;
         wb_q    <= '0;
         sel_a_q <= SEL_REGFILE;
         sel_b_q <= SEL_REGFILE;
      end else begin
         ex_q    <= ex_d;
         mem_q   <= mem_d;
         wb_q    <= wb_d;
         sel_a_q <= sel_a_d;
         sel_b_q <= sel_b_d;
      end
   end

   assign fwd_a_sel_o = sel_a_q;
   assign fwd_b_sel_o = sel_b_q;

`ifdef OPERAND_FORWARD_STALL_COUNT_EN
   logic [31:0] stall_count_q, stall_count_d;

   // Wraps naturally from 0xFFFFFFFF to 0.
   always_comb begin
      stall_count_d = stall_count_q;
      if (enable_i && stall_o) begin
         stall_count_d = stall_count_q + 32'd1;
      end
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         stall_count_q <= '0;
      end else begin
         stall_count_q <= stall_count_d;
      end
   end

   assign stall_count_o = stall_count_q;
`endif

endmodule

// File: tb/tb_operand_forward_ctrl.sv
// ----------------------------------------------------------------------------
// tb_operand_forward_ctrl
// Table-driven bench: each record is one ID-stage instruction with the
// expected combinational stall and the selects expected one edge later.
// ----------------------------------------------------------------------------
module tb_operand_forward_ctrl;

   logic       clock_i = 1'b0;
   logic       reset_i;
   logic       enable_i;
   logic       flush_i;
   logic       id_valid_i;
   logic [4:0] id_rs_i;
   logic [4:0] id_rt_i;
   logic       id_use_rs_i;
   logic       id_use_rt_i;
   logic       id_reg_write_i;
   logic [4:0] id_dest_i;
   logic       id_mem_read_i;
   logic       stall_o;
   logic [1:0] fwd_a_sel_o;
   logic [1:0] fwd_b_sel_o;
   logic [31:0] stall_count;

   int tests_run = 0;
   int tests_failed = 0;
   int exp_count = 0;

   always #5 clock_i = ~clock_i;

   operand_forward_ctrl dut (
      .clock_i        (clock_i),
      .reset_i        (reset_i),
      .enable_i       (enable_i),
      .flush_i        (flush_i),
      .id_valid_i     (id_valid_i),
      .id_rs_i        (id_rs_i),
      .id_rt_i        (id_rt_i),
      .id_use_rs_i    (id_use_rs_i),
      .id_use_rt_i    (id_use_rt_i),
      .id_reg_write_i (id_reg_write_i),
      .id_dest_i      (id_dest_i),
      .id_mem_read_i  (id_mem_read_i),
      .stall_o        (stall_o),
      .fwd_a_sel_o    (fwd_a_sel_o),
`ifdef OPERAND_FORWARD_STALL_COUNT_EN
      .stall_count_o  (stall_count),
`endif
      .fwd_b_sel_o    (fwd_b_sel_o)
   );

`ifndef OPERAND_FORWARD_STALL_COUNT_EN
   assign stall_count = '0;
`endif

   typedef struct {
      logic       en, flush, valid;
      logic [4:0] rs, rt;
      logic       urs, urt, wr, mr;
      logic [4:0] dest;
      logic       exp_stall;
      logic [1:0] exp_a, exp_b;
   } vec_t;

   vec_t       tbl[$];
   logic [3:0] sel_sb[$];

   function automatic vec_t mk(logic en, logic flush, logic valid, logic [4:0] rs,
                               logic [4:0] rt, logic urs, logic urt, logic wr, logic mr,
                               logic [4:0] dest, logic st, logic [1:0] a, logic [1:0] b);
      vec_t v;
      v.en = en; v.flush = flush; v.valid = valid; v.rs = rs; v.rt = rt;
      v.urs = urs; v.urt = urt; v.wr = wr; v.mr = mr; v.dest = dest;
      v.exp_stall = st; v.exp_a = a; v.exp_b = b;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input vec_t v);
      enable_i = v.en; flush_i = v.flush; id_valid_i = v.valid;
      id_rs_i = v.rs; id_rt_i = v.rt; id_use_rs_i = v.urs; id_use_rt_i = v.urt;
      id_reg_write_i = v.wr; id_mem_read_i = v.mr; id_dest_i = v.dest;
   endtask

   // Drive at negedge, check stall before the edge, compare selects after it.
   task automatic apply(input int idx, input vec_t v);
      logic [3:0] exp_sel;
      @(negedge clock_i);
      drive(v);
      sel_sb.push_back({v.exp_a, v.exp_b});
      #1;
      check($sformatf("stall[%0d]", idx), 32'(stall_o), 32'(v.exp_stall));
      if (v.en && v.exp_stall) exp_count++;
      @(posedge clock_i);
      #1;
      if (sel_sb.size() == 0) begin
         check($sformatf("scoreboard_empty[%0d]", idx), 32'd0, 32'd1);
      end else begin
         exp_sel = sel_sb.pop_front();
         check($sformatf("sel_a[%0d]", idx), 32'(fwd_a_sel_o), 32'(exp_sel[3:2]));
         check($sformatf("sel_b[%0d]", idx), 32'(fwd_b_sel_o), 32'(exp_sel[1:0]));
      end
`ifdef OPERAND_FORWARD_STALL_COUNT_EN
      check($sformatf("stall_count[%0d]", idx), stall_count, 32'(exp_count));
`endif
   endtask

   initial begin
      //               en fl v  rs  rt u  u  wr mr dest st a     b
      tbl.push_back(mk(1, 0, 1, 1,  2, 1, 1, 1, 0, 3,  0, 2'b00, 2'b00)); // add $3
      tbl.push_back(mk(1, 0, 1, 3,  4, 1, 1, 1, 0, 6,  0, 2'b01, 2'b00)); // sub rs=$3
      tbl.push_back(mk(1, 0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 2'b00, 2'b00)); // nop
      tbl.push_back(mk(1, 0, 1, 1,  1, 1, 1, 1, 0, 7,  0, 2'b00, 2'b00)); // add $7
      tbl.push_back(mk(1, 0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 2'b00, 2'b00)); // nop
      tbl.push_back(mk(1, 0, 1, 2,  7, 1, 1, 1, 0, 8,  0, 2'b00, 2'b10)); // or rt=$7
      tbl.push_back(mk(1, 0, 1, 1,  2, 1, 1, 1, 0, 9,  0, 2'b00, 2'b00)); // add $9
      tbl.push_back(mk(1, 0, 1, 1,  1, 1, 1, 1, 0, 9,  0, 2'b00, 2'b00)); // add $9 again
      tbl.push_back(mk(1, 0, 1, 9,  9, 1, 1, 1, 0, 10, 0, 2'b01, 2'b01)); // youngest wins
      tbl.push_back(mk(1, 0, 1, 1,  5, 1, 0, 1, 1, 5,  0, 2'b00, 2'b00)); // lw $5
      tbl.push_back(mk(1, 0, 1, 5,  2, 1, 1, 1, 0, 11, 1, 2'b00, 2'b00)); // load-use stall
      tbl.push_back(mk(1, 0, 1, 5,  2, 1, 1, 1, 0, 11, 0, 2'b10, 2'b00)); // replay
      tbl.push_back(mk(1, 0, 1, 1,  1, 1, 1, 1, 0, 0,  0, 2'b00, 2'b00)); // write $0
      tbl.push_back(mk(1, 0, 1, 0,  0, 1, 1, 1, 0, 12, 0, 2'b00, 2'b00)); // read $0
      tbl.push_back(mk(1, 0, 1, 1,  1, 1, 0, 1, 1, 13, 0, 2'b00, 2'b00)); // lw $13
      tbl.push_back(mk(1, 1, 1, 13, 13, 1, 1, 1, 0, 14, 0, 2'b00, 2'b00)); // flush wins
      tbl.push_back(mk(1, 0, 1, 13, 13, 1, 1, 1, 0, 14, 0, 2'b10, 2'b10));
      tbl.push_back(mk(1, 0, 1, 14, 14, 0, 1, 1, 0, 15, 0, 2'b00, 2'b01)); // rs unused
      tbl.push_back(mk(1, 0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 2'b00, 2'b00)); // nop
      tbl.push_back(mk(1, 0, 1, 14, 15, 1, 1, 1, 0, 16, 0, 2'b00, 2'b10)); // $14 only in WB
      tbl.push_back(mk(1, 0, 1, 16, 0, 1, 0, 1, 1, 20, 0, 2'b01, 2'b00)); // lw $20
      tbl.push_back(mk(0, 0, 1, 20, 1, 1, 1, 1, 0, 22, 0, 2'b01, 2'b00)); // frozen x3
      tbl.push_back(mk(0, 0, 1, 20, 1, 1, 1, 1, 0, 22, 0, 2'b01, 2'b00));
      tbl.push_back(mk(0, 0, 1, 20, 1, 1, 1, 1, 0, 22, 0, 2'b01, 2'b00));
      tbl.push_back(mk(1, 0, 1, 20, 1, 1, 1, 1, 0, 22, 1, 2'b00, 2'b00)); // stall resumes
      tbl.push_back(mk(1, 0, 1, 20, 1, 1, 1, 1, 0, 22, 0, 2'b10, 2'b00));
      tbl.push_back(mk(1, 0, 1, 22, 0, 1, 0, 1, 1, 23, 0, 2'b01, 2'b00)); // lw $23

      // Reset state
      reset_i = 1'b1;
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00));
      #2;
      check("reset_stall", 32'(stall_o), 32'd0);
      check("reset_sel_a", 32'(fwd_a_sel_o), 32'd0);
      check("reset_sel_b", 32'(fwd_b_sel_o), 32'd0);
      check("reset_count", stall_count, 32'd0);
      @(negedge clock_i);
      reset_i = 1'b0;

      for (int i = 0; i < tbl.size(); i++) begin
         apply(i, tbl[i]);
      end

      // Asynchronous reset in the middle of a load-use stall.
      @(negedge clock_i);
      drive(mk(1, 0, 1, 23, 0, 1, 0, 1, 0, 24, 0, 2'b00, 2'b00));
      #1;
      check("pre_reset_stall", 32'(stall_o), 32'd1);
      check("pre_reset_sel_a", 32'(fwd_a_sel_o), 32'd1);
      #2;
      reset_i = 1'b1;
      #1;
      check("async_reset_stall", 32'(stall_o), 32'd0);
      check("async_reset_sel_a", 32'(fwd_a_sel_o), 32'd0);
      check("async_reset_sel_b", 32'(fwd_b_sel_o), 32'd0);
      check("async_reset_count", stall_count, 32'd0);
      exp_count = 0;
      @(negedge clock_i);
      reset_i = 1'b0;
      // Load was cleared by reset, so the consumer proceeds without a stall.
      apply(100, mk(1, 0, 1, 23, 0, 1, 0, 1, 0, 24, 0, 2'b00, 2'b00));

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   // Safety net so the run always terminates.
   initial begin
      #20000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/operand_forward_ctrl.md
Name: operand_forward_ctrl

Overview:
- Sequencing controller for the two 3-input EX-stage operand multiplexers (ALU A/B) in the MIPS pipeline.
- Tracks the destination register of the instructions in EX, MEM and WB in an internal shadow pipeline.
- Drives the 2-bit mux selects so dependent instructions take forwarded results instead of stale register-file data.
- Detects load-use hazards and issues a one-cycle stall with bubble insertion.

Parameters:
- NB_REG, 5, width of register specifiers.
- NB_SEL, 2, width of the mux select outputs. Fixed at 2; must match the mux select width.

Ports:
- clock_i  in  1  system clock, rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- enable_i  in  1  pipeline advance enable. When low, all state is frozen (debug step / halt).
- flush_i  in  1  squash the instruction currently in ID (taken branch/jump).
- id_valid_i  in  1  ID stage holds a real instruction.
- id_rs_i  in  NB_REG  source register A of the ID instruction.
- id_rt_i  in  NB_REG  source register B of the ID instruction.
- id_use_rs_i  in  1  ID instruction reads rs.
- id_use_rt_i  in  1  ID instruction reads rt.
- id_reg_write_i  in  1  ID instruction writes a register.
- id_dest_i  in  NB_REG  destination register of the ID instruction (rd or rt, already resolved).
- id_mem_read_i  in  1  ID instruction is a load.
- stall_o  out  1  hold PC and IF/ID; combinational.
- fwd_a_sel_o  out  NB_SEL  ALU operand A mux select; registered.
- fwd_b_sel_o  out  NB_SEL  ALU operand B mux select; registered.

Behaviour:
- Select encoding (matches mux inputs):
  - 00 = register-file operand
  - 01 = EX/MEM ALU result
  - 10 = MEM/WB write-back data
  - 11 is never driven.
- Internal slots EX, MEM and WB each hold {valid, reg_write, mem_read, dest}. A slot is a "producer" when valid & reg_write & dest!=0.
- Register $0 is never forwarded. A match on dest==0 is ignored.
- stall_o = enable_i & !flush_i & id_valid_i & EX.valid & EX.mem_read & EX.reg_write & EX.dest!=0 & ((id_use_rs_i & id_rs_i==EX.dest) | (id_use_rt_i & id_rt_i==EX.dest)).
- On each rising edge with enable_i=1:
  - WB <= MEM; MEM <= EX.
  - EX <= bubble (valid=0) if stall_o or flush_i or !id_valid_i; otherwise EX <= ID fields.
  - fwd_a_sel_o is computed from the pre-edge slots for the instruction entering EX:
    - 01 if the EX slot is a producer and EX.dest==id_rs_i
    - else 10 if the MEM slot is a producer and MEM.dest==id_rs_i
    - else 00.
  - fwd_b_sel_o uses the same rule with id_rt_i.
  - The EX-slot match always wins over the MEM-slot match (youngest producer priority).
  - A select is forced to 00 when the corresponding id_use_*_i=0 or the EX slot is loaded with a bubble.
- Latency: selects are valid in the same cycle the consumer occupies EX, i.e. one cycle after the ID-stage inputs are sampled.
- Load-use: exactly one stall cycle. The next cycle the load is in MEM, so the consumer re-evaluates and gets 10.
- Producer three stages back (in WB when the consumer is in ID): no forwarding. The register file writes before it reads, so select 00 is correct.
- enable_i=0: no slot, select or counter changes. stall_o is 0.
- flush_i together with a stall condition: flush wins. stall_o=0 and EX <= bubble.
- Reset (asynchronous, any time, including mid-stall):
  - all slots valid=0
  - fwd_a_sel_o=fwd_b_sel_o=00
  - stall_o=0
  - stall counter=0.

Optional Feature:
- Macro: OPERAND_FORWARD_STALL_COUNT_EN.
- When defined:
  - Adds output stall_count_o [31:0].
  - Increments on every edge where enable_i & stall_o; wraps from 0xFFFFFFFF to 0.
  - Reset value 0. Read by the debug unit.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - the select encoding constants SEL_REGFILE=2'b00, SEL_EXMEM=2'b01, SEL_MEMWB=2'b10
  - NB_REG
  - the slot record layout {valid, reg_write, mem_read, dest}.
- One natural sub-module: fwd_sel_compare. It is purely combinational: a source register plus the EX and MEM slots give a 2-bit select. It is instantiated twice (rs, rt).

Test Plan:
- add $3 in ID, next cycle sub with rs=$3 in ID → fwd_a_sel_o=01 when sub is in EX; stall_o never 1.
- add $3, nop, then or with rt=$3 → fwd_b_sel_o=10.
- add $3 and add $3 back-to-back, then consumer rs=$3 → select 01 (youngest wins).
- lw $5 then add with rs=$5:
  - stall_o=1 for exactly one cycle and the EX slot is a bubble
  - then fwd_a_sel_o=10
  - stall counter increments by 1 when the macro is on.
- Producer with dest=$0 followed by a consumer reading $0 → selects 00.
- Flush and reset cases:
  - flush_i asserted during a load-use condition → stall_o=0 and EX bubble.
  - reset_i pulsed mid-stall → all outputs 00/0 asynchronously.
  - enable_i=0 for 3 cycles → selects hold their values.
